// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizing for the register file write arbiter.
package regfile_ctrl_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 5;
  localparam int unsigned DefNreq  = 3;

  // Wide enough to index any supported requester count (2..4).
  localparam int unsigned IdxWidth = 2;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin select: first valid requester at or after the pointer.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq
) (
  input  logic [NREQ-1:0]     valid_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NREQ-1:0]     grant_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_valid_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (int'(ptr_i) + k) % int'(NREQ);
      if (!found && valid_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IdxWidth'(j);
      end
    end
    any_valid_o = |valid_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with a full-clear sequencer.
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned NREQ  = DefNreq
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DEPTH-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    WE3,
  output logic [DEPTH-1:0]        A3,
  output logic [WIDTH-1:0]        WD3
);

  localparam logic [DEPTH:0] CntOne  = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] CntLast = {1'b1, {DEPTH{1'b0}}};

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic [DEPTH:0]        cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DEPTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      wd_q, wd_d;
  logic                  done_q, done_d;

  logic [NREQ-1:0]       grant;
  logic [IdxWidth-1:0]   gnt_idx;
  logic                  any_valid;
  logic [DEPTH-1:0]      sel_addr;
  logic [WIDTH-1:0]      sel_data;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .valid_i    (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .idx_o      (gnt_idx),
    .any_valid_o(any_valid)
  );

  assign sel_addr = req_addr[int'(gnt_idx)*DEPTH +: DEPTH];
  assign sel_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !clr_start && !reset) begin
      req_ready = grant;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    a_d     = a_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          we_d    = 1'b1;
          a_d     = '0;
          wd_d    = '0;
          cnt_d   = CntOne;
        end else if (any_valid) begin
          // r0 is hardwired zero: accept the request but suppress the write.
          we_d  = (sel_addr != '0);
          a_d   = sel_addr;
          wd_d  = sel_data;
          ptr_d = (gnt_idx == IdxWidth'(NREQ - 1)) ? '0 : gnt_idx + IdxWidth'(1);
        end
      end
      StClear: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          we_d  = 1'b1;
          a_d   = cnt_q[DEPTH-1:0];
          wd_d  = '0;
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  assign clr_busy = (state_q == StClear);
  assign clr_done = done_q;
  assign WE3      = we_q;
  assign A3       = a_q;
  assign WD3      = wd_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (WIDTH=32, DEPTH=5, NREQ=3).
module tb_regfile_write_arbiter;

  localparam int W = 32;
  localparam int D = 5;
  localparam int N = 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*D-1:0] req_addr;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           clr_start;
  logic           clr_busy;
  logic           clr_done;
  logic           WE3;
  logic [D-1:0]   A3;
  logic [W-1:0]   WD3;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(
    .WIDTH(W),
    .DEPTH(D),
    .NREQ (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .WE3      (WE3),
    .A3       (A3),
    .WD3      (WD3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [D-1:0] a, input logic [W-1:0] d);
    req_addr[i*D +: D] = a;
    req_data[i*W +: W] = d;
  endtask

  initial begin
    logic [2:0] exp_gnt [6];
    logic [D-1:0] addrs [3];
    logic [W-1:0] datas [3];
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    addrs   = '{5'd1, 5'd2, 5'd3};
    datas   = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};

    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clr_start = 1'b0;
    #3;
    check("rst_we3", 64'(WE3), 64'd0);
    check("rst_a3", 64'(A3), 64'd0);
    check("rst_wd3", 64'(WD3), 64'd0);
    check("rst_busy", 64'(clr_busy), 64'd0);
    check("rst_done", 64'(clr_done), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single write from requester 0.
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1;
    check("single_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("single_we3", 64'(WE3), 64'd1);
    check("single_a3", 64'(A3), 64'd5);
    check("single_wd3", 64'(WD3), 64'hDEAD_BEEF);
    tick();
    check("single_we3_off", 64'(WE3), 64'd0);
    check("single_a3_hold", 64'(A3), 64'd5);

    // Requester 2 alone brings the pointer back to 0.
    set_req(2, 5'd9, 32'h0000_0022);
    req_valid = 3'b100;
    #1;
    check("r2_ready", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    check("r2_a3", 64'(A3), 64'd9);
    tick();

    // Fairness with all three requesters valid.
    for (int i = 0; i < 3; i++) set_req(i, addrs[i], datas[i]);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("fair_ready_%0d", c), 64'(req_ready), 64'(exp_gnt[c]));
      tick();
      check($sformatf("fair_we3_%0d", c), 64'(WE3), 64'd1);
      check($sformatf("fair_a3_%0d", c), 64'(A3), 64'(addrs[c % 3]));
      check($sformatf("fair_wd3_%0d", c), 64'(WD3), 64'(datas[c % 3]));
    end
    req_valid = '0;
    tick();
    check("fair_we3_off", 64'(WE3), 64'd0);

    // Address 0 is accepted but never written.
    set_req(1, 5'd0, 32'd7);
    req_valid = 3'b010;
    #1;
    check("a0_ready", 64'(req_ready), 64'b010);
    tick();
    check("a0_we3", 64'(WE3), 64'd0);
    set_req(1, addrs[1], datas[1]);
    req_valid = 3'b111;
    #1;
    check("a0_next_ready", 64'(req_ready), 64'b100);
    tick();
    check("a0_next_a3", 64'(A3), 64'(addrs[2]));
    req_valid = '0;
    tick();

    // Clear sweep, with a redundant clr_start mid-sweep that must be ignored.
    req_valid = 3'b111;
    clr_start = 1'b1;
    #1;
    check("clr_start_ready", 64'(req_ready), 64'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      clr_start = (i == 5);
      #1;
      check($sformatf("clr_we3_%0d", i), 64'(WE3), 64'd1);
      check($sformatf("clr_a3_%0d", i), 64'(A3), 64'(i));
      check($sformatf("clr_wd3_%0d", i), 64'(WD3), 64'd0);
      check($sformatf("clr_busy_%0d", i), 64'(clr_busy), 64'd1);
      check($sformatf("clr_done_%0d", i), 64'(clr_done), 64'd0);
      check($sformatf("clr_ready_%0d", i), 64'(req_ready), 64'd0);
      tick();
    end
    clr_start = 1'b0;
    #1;
    check("clr_end_done", 64'(clr_done), 64'd1);
    check("clr_end_we3", 64'(WE3), 64'd0);
    check("clr_end_busy", 64'(clr_busy), 64'd0);
    check("clr_end_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("post_clr_done", 64'(clr_done), 64'd0);
    check("post_clr_we3", 64'(WE3), 64'd1);
    check("post_clr_a3", 64'(A3), 64'(addrs[0]));
    tick();

    // Abort a sweep with reset at sweep cycle 10.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("abort_pre_a3", 64'(A3), 64'd10);
    req_valid = 3'b111;
    reset = 1'b1;
    #1;
    check("abort_we3", 64'(WE3), 64'd0);
    check("abort_a3", 64'(A3), 64'd0);
    check("abort_wd3", 64'(WD3), 64'd0);
    check("abort_busy", 64'(clr_busy), 64'd0);
    check("abort_done", 64'(clr_done), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    req_valid = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_no_done_%0d", i), 64'(clr_done), 64'd0);
    end
    req_valid = 3'b111;
    #1;
    check("abort_ptr_reset", 64'(req_ready), 64'b001);
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
